// File: rtl/xgriscv_lsu_pkg.sv
// Shared definitions for the load/store unit: data width, funct3 codes, FSM states
// and small request-decode helpers.
package xgriscv_lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_RESP,
    S_ERR
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    return (f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/xgriscv_lsu_lane.sv
// Byte-lane helper: builds the dmem lane mask, shifts the addressed lane of read data
// down to bit 0, and sign/zero-extends the assembled load value.
module xgriscv_lsu_lane
  import xgriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
) (
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic [1:0]      ext_size,
  input  logic            uns,
  input  logic [XLEN-1:0] rd,
  input  logic [XLEN-1:0] rbuf,
  output logic [3:0]      amp,
  output logic [XLEN-1:0] lane,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    amp = 4'b0000;
    case (size)
      2'b00:   amp = 4'b0001 << off;
      2'b01:   amp = 4'b0011 << off;
      default: amp = 4'b1111;
    endcase
  end

  assign lane = rd >> {off, 3'b000};

  always_comb begin
    ext = rbuf;
    case (ext_size)
      2'b00:   ext = uns ? {{(XLEN-8){1'b0}}, rbuf[7:0]}
                         : {{(XLEN-8){rbuf[7]}}, rbuf[7:0]};
      2'b01:   ext = uns ? {{(XLEN-16){1'b0}}, rbuf[15:0]}
                         : {{(XLEN-16){rbuf[15]}}, rbuf[15:0]};
      default: ext = rbuf;
    endcase
  end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit between the MEM stage and dmem: one request per handshake,
// misaligned accesses optionally serialised into single-byte dmem cycles.
module xgriscv_lsu
  import xgriscv_lsu_pkg::*;
#(
  parameter int unsigned XLEN        = LSU_XLEN,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            dmem_we,
  output logic [3:0]      dmem_amp,
  output logic [XLEN-1:0] dmem_a,
  output logic [XLEN-1:0] dmem_wd,
  input  logic [XLEN-1:0] dmem_rd
);

  lsu_state_e state_q, state_d;

  logic            we_q, mis_q;
  logic [2:0]      f3_q;
  logic [1:0]      cnt_q;
  logic [XLEN-1:0] addr_q, wdata_q, rbuf_q;

  logic            hs, req_mis, req_err, last, active;
  logic [1:0]      acc_size;
  logic [3:0]      amp;
  logic [7:0]      wbyte;
  logic [XLEN-1:0] cur_a, lane, ext;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign hs        = req_valid && req_ready;
  assign req_mis   = misaligned(req_funct3, req_addr[1:0]);
  assign req_err   = !f3_legal(req_we, req_funct3) || (req_mis && !MISALIGN_EN);

  // cnt_q stays 0 for aligned accesses, so cur_a/wbyte reduce to the plain case
  assign cur_a    = addr_q + XLEN'(cnt_q);
  assign acc_size = mis_q ? 2'b00 : f3_q[1:0];
  assign last     = !mis_q || (cnt_q == last_idx(f3_q));
  assign active   = (state_q == S_ACC) && !reset;
  assign wbyte    = wdata_q[{cnt_q, 3'b000} +: 8];

  xgriscv_lsu_lane #(.XLEN(XLEN)) u_lane (
    .off      (cur_a[1:0]),
    .size     (acc_size),
    .ext_size (f3_q[1:0]),
    .uns      (f3_q[2]),
    .rd       (dmem_rd),
    .rbuf     (rbuf_q),
    .amp      (amp),
    .lane     (lane),
    .ext      (ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hs) state_d = req_err ? S_ERR : S_ACC;
      S_ACC:   if (last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_we  = 1'b0;
    dmem_amp = '0;
    dmem_a   = '0;
    dmem_wd  = '0;
    if (active) begin
      dmem_we  = we_q;
      dmem_amp = amp;
      dmem_a   = cur_a;
      if (we_q) begin
        case (acc_size)
          2'b00:   dmem_wd = {4{wbyte}};
          2'b01:   dmem_wd = {2{wdata_q[15:0]}};
          default: dmem_wd = wdata_q;
        endcase
      end
    end
  end

  assign resp_valid = ((state_q == S_RESP) || (state_q == S_ERR)) && !reset;
  assign resp_err   = (state_q == S_ERR) && !reset;
  assign resp_rdata = ((state_q == S_RESP) && !we_q && !reset) ? ext : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      f3_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mis_q   <= req_mis && MISALIGN_EN;
        cnt_q   <= '0;
        rbuf_q  <= '0;
      end else if (state_q == S_ACC) begin
        cnt_q <= cnt_q + 2'd1;
        if (!we_q) begin
          if (mis_q) rbuf_q[{cnt_q, 3'b000} +: 8] <= lane[7:0];
          else       rbuf_q <= lane;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Directed bench for xgriscv_lsu with a byte-addressed dmem model; a second
// instance covers the MISALIGN_EN=0 error path.
module tb_xgriscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_we;
  logic [3:0]  dmem_amp;
  logic [31:0] dmem_a, dmem_wd, dmem_rd;

  logic        r2_valid, r2_ready, r2_we;
  logic [2:0]  r2_funct3;
  logic [31:0] r2_addr, r2_wdata;
  logic        resp2_valid, resp2_err;
  logic [31:0] resp2_rdata;
  logic        dmem2_we;
  logic [3:0]  dmem2_amp;
  logic [31:0] dmem2_a, dmem2_wd;
  logic [31:0] dmem2_rd = '0;

  logic [7:0]  mem [512];
  logic        mem_clr;
  logic        ill_win;
  int          ill_we  = 0;
  int          we2_cnt = 0;
  int          checks  = 0;
  int          passes  = 0;

  always #5 clk = ~clk;

  xgriscv_lsu #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_we(dmem_we), .dmem_amp(dmem_amp), .dmem_a(dmem_a),
    .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
  );

  xgriscv_lsu #(.XLEN(32), .MISALIGN_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
    .req_funct3(r2_funct3), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .resp_valid(resp2_valid), .resp_rdata(resp2_rdata), .resp_err(resp2_err),
    .dmem_we(dmem2_we), .dmem_amp(dmem2_amp), .dmem_a(dmem2_a),
    .dmem_wd(dmem2_wd), .dmem_rd(dmem2_rd)
  );

  // dmem returns the whole word containing dmem_a
  always_comb begin
    logic [8:0] w;
    w = {dmem_a[8:2], 2'b00};
    dmem_rd = {mem[w + 9'd3], mem[w + 9'd2], mem[w + 9'd1], mem[w]};
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (dmem_we) begin
      for (int i = 0; i < 4; i++)
        if (dmem_amp[i]) mem[{dmem_a[8:2], 2'(i)}] <= dmem_wd[8*i +: 8];
    end
    if (dmem_we && ill_win) ill_we++;
    if (dmem2_we) we2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request and wait (bounded) for its response; checks ACC cycle count,
  // rdata and err. Returns one cycle after the response, back in IDLE.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_acc, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bit got;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      if (resp_valid) got = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_acc_cycles"}, n, exp_acc);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ma   [4];
    logic [3:0]  mamp [4];
    logic [31:0] mwd  [4];
    ma   = '{32'h103, 32'h104, 32'h105, 32'h106};
    mamp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    mwd  = '{32'hEFEFEFEF, 32'hBEBEBEBE, 32'hADADADAD, 32'hDEDEDEDE};

    reset = 1'b1; mem_clr = 1'b1; ill_win = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    r2_valid = 1'b0; r2_we = 1'b0; r2_funct3 = '0; r2_addr = '0; r2_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_amp", 32'(dmem_amp), 32'd0);
    chk("rst_dmem_a", dmem_a, 32'd0);
    reset = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    // 1: aligned SW with per-cycle timing, then LW
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sw_we", 32'(dmem_we), 32'd1);
    chk("sw_amp", 32'(dmem_amp), 32'hF);
    chk("sw_a", dmem_a, 32'h100);
    chk("sw_wd", dmem_wd, 32'h11223344);
    chk("sw_resp_early", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("sw_resp", 32'(resp_valid), 32'd1);
    chk("sw_resp_we", 32'(dmem_we), 32'd0);
    @(posedge clk); #1;
    chk("sw_idle_ready", 32'(req_ready), 32'd1);
    xact("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h11223344, 1'b0);

    // 2: byte/half extension
    xact("sw8899", 1'b1, 3'b010, 32'h100, 32'h8899AABB, 1, 32'h0, 1'b0);
    xact("lb101", 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'hFFFFFFAA, 1'b0);
    xact("lbu101", 1'b0, 3'b100, 32'h101, 32'h0, 1, 32'h000000AA, 1'b0);
    xact("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'hFFFF8899, 1'b0);
    xact("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h00008899, 1'b0);

    // 3: misaligned SW, bytewise
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("msw_a%0d", i), dmem_a, ma[i]);
      chk($sformatf("msw_amp%0d", i), 32'(dmem_amp), 32'(mamp[i]));
      chk($sformatf("msw_we%0d", i), 32'(dmem_we), 32'd1);
      chk($sformatf("msw_wd%0d", i), dmem_wd, mwd[i]);
      @(posedge clk); #1;
    end
    chk("msw_resp", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    xact("lw103", 1'b0, 3'b010, 32'h103, 32'h0, 4, 32'hDEADBEEF, 1'b0);
    xact("lw104", 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h00DEADBE, 1'b0);
    xact("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 2, 32'hFFFF99AA, 1'b0);
    xact("lhu103", 1'b0, 3'b101, 32'h103, 32'h0, 2, 32'h0000BEEF, 1'b0);

    // 3b: MISALIGN_EN=0 -> immediate error, no write
    r2_valid = 1'b1; r2_we = 1'b1; r2_funct3 = 3'b010; r2_addr = 32'h103; r2_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    chk("nomis_resp", 32'(resp2_valid), 32'd1);
    chk("nomis_err", 32'(resp2_err), 32'd1);
    chk("nomis_rdata", resp2_rdata, 32'd0);
    @(posedge clk); #1;
    chk("nomis_no_we", we2_cnt, 0);

    // 4: illegal funct3
    ill_win = 1'b1;
    xact("ill_ld011", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1);
    xact("ill_st100", 1'b1, 3'b100, 32'h100, 32'hCAFEF00D, 0, 32'h0, 1'b1);
    ill_win = 1'b0;
    chk("ill_no_we", ill_we, 0);

    // 5: reset during the third byte of a misaligned SW
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmid_a_before", dmem_a, 32'h105);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rmid_resp", 32'(resp_valid), 32'd0);
    chk("rmid_we", 32'(dmem_we), 32'd0);
    chk("rmid_amp", 32'(dmem_amp), 32'd0);
    chk("rmid_a", dmem_a, 32'd0);
    chk("rmid_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rmid_ready_after", 32'(req_ready), 32'd1);
    chk("rmid_m103", 32'(mem[9'h103]), 32'hEF);
    chk("rmid_m104", 32'(mem[9'h104]), 32'hBE);
    chk("rmid_m105", 32'(mem[9'h105]), 32'h00);
    chk("rmid_m106", 32'(mem[9'h106]), 32'h00);
    @(posedge clk); #1;
    chk("rmid_no_resp", 32'(resp_valid), 32'd0);

    // 6: back-to-back with req_valid held high
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h108; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'hFFFFFFFF;
    chk("b2b_acc_ready", 32'(req_ready), 32'd0);
    chk("b2b_acc_we", 32'(dmem_we), 32'd1);
    chk("b2b_acc_a", dmem_a, 32'h108);
    chk("b2b_acc_wd", dmem_wd, 32'h55667788);
    @(posedge clk); #1;
    chk("b2b_resp", 32'(resp_valid), 32'd1);
    chk("b2b_resp_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_resp", 32'(resp_valid), 32'd0);
    chk("b2b_idle_we", 32'(dmem_we), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_acc2_we", 32'(dmem_we), 32'd0);
    chk("b2b_acc2_a", dmem_a, 32'h108);
    chk("b2b_acc2_amp", 32'(dmem_amp), 32'hF);
    chk("b2b_acc2_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp2", 32'(resp_valid), 32'd1);
    chk("b2b_rdata2", resp_rdata, 32'h55667788);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
